// File: rtl/ysyx_25020047_ifu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25020047_pkg
// Shared definitions for the instruction fetch unit:
//   ifu_state_e       fetch FSM states
//   RESET_PC_DEFAULT  fetch address after reset
//   INST_NOP          canonical RV32 nop (addi x0, x0, 0)
//   XLEN              address / instruction width (only 32 is supported)
// ---------------------------------------------------------------------------
package ysyx_25020047_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ysyx_25020047_ifu_if.sv
// ---------------------------------------------------------------------------
// ysyx_25020047_ifu_if
// Bundles the IFU's three handshakes:
//   imem request   : imem_req_valid / imem_req_ready / imem_req_addr
//   imem response  : imem_rsp_valid / imem_rsp_ready / imem_rsp_data / imem_rsp_err
//   redirect       : redirect_valid (one-cycle pulse) / redirect_pc
//   decode output  : inst_valid / inst_ready / inst / inst_pc / inst_snpc / inst_err
// Modports:
//   master - the IFU side (drives requests and the decode output)
//   slave  - the environment side (memory, execute/writeback, decode)
// ---------------------------------------------------------------------------
interface ysyx_25020047_ifu_if;
    import ysyx_25020047_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;

    logic            imem_rsp_valid;
    logic            imem_rsp_ready;
    logic [XLEN-1:0] imem_rsp_data;
    logic            imem_rsp_err;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_snpc;
    logic            inst_err;

    modport master (
        output imem_req_valid, imem_req_addr, imem_rsp_ready,
               inst_valid, inst, inst_pc, inst_snpc, inst_err,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, imem_rsp_ready,
               inst_valid, inst, inst_pc, inst_snpc, inst_err,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
               redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/ysyx_25020047_ifu_perfcnt.sv
// ---------------------------------------------------------------------------
// ysyx_25020047_perfcnt
// Generic event counter: increments by one on every clock edge where en is
// high, wraps modulo 2^W.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset (count -> 0)
//   en   in   count enable
//   cnt  out  current count
// ---------------------------------------------------------------------------
module ysyx_25020047_perfcnt
    import ysyx_25020047_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/ysyx_25020047_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_25020047_ifu
// Instruction fetch unit in front of decode. Owns the fetch PC, issues one
// word fetch at a time to instruction memory, presents the fetched word with
// its PC to decode, and discards fetches made stale by a redirect.
//
// Parameters:
//   XLEN      address / instruction width (only 32 is supported)
//   RESET_PC  first fetch address after reset
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset
//   bus   ysyx_25020047_ifu_if.master (imem request/response, redirect,
//         decode output handshake)
//   perf_fetch_cnt / perf_stall_cnt  out  only when YSYX_25020047_IFU_PERF_EN
//         is defined: instructions handed to decode, cycles spent in REQ/WAIT
//
// Optional feature macro: YSYX_25020047_IFU_PERF_EN
// ---------------------------------------------------------------------------
module ysyx_25020047_ifu
    import ysyx_25020047_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_25020047_ifu_if.master        bus
`ifdef YSYX_25020047_IFU_PERF_EN
    ,
    output logic [31:0]                perf_fetch_cnt,
    output logic [31:0]                perf_stall_cnt
`endif
);

    ifu_state_e      state;
    ifu_state_e      state_nxt;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic            drop;
    logic            drop_nxt;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic [XLEN-1:0] inst_snpc_q;
    logic            inst_err_q;

    // Decisions produced by the next-state logic for the datapath registers.
    logic            enter_req;   // leaving current state towards a fresh fetch
    logic            misaligned;  // that fresh fetch address is not word aligned
    logic            cap_rsp;     // latch a good memory response for decode
    logic            cap_fault;   // latch a misaligned-PC fault for decode

    logic            req_valid;
    logic            rsp_ready;
    logic            inst_valid;

    logic            req_fire;
    logic            rsp_fire;
    logic            inst_fire;

    assign req_fire  = req_valid  && bus.imem_req_ready;
    assign rsp_fire  = rsp_ready  && bus.imem_rsp_valid;
    assign inst_fire = inst_valid && bus.inst_ready;

    assign misaligned = (pc_nxt[1:0] != 2'b00);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and PC selection
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_nxt  = drop;
        enter_req = 1'b0;
        cap_rsp   = 1'b0;
        cap_fault = 1'b0;

        case (state)
            IDLE: begin
                if (bus.redirect_valid) begin
                    pc_nxt = bus.redirect_pc;
                end
                enter_req = 1'b1;
            end

            REQ: begin
                // The request on the bus is already visible to memory, so a
                // redirect cannot withdraw it; its response gets discarded.
                if (bus.redirect_valid) begin
                    pc_nxt   = bus.redirect_pc;
                    drop_nxt = 1'b1;
                end
                if (req_fire) begin
                    state_nxt = WAIT;
                end
            end

            WAIT: begin
                if (bus.redirect_valid) begin
                    pc_nxt   = bus.redirect_pc;
                    drop_nxt = 1'b1;
                end
                if (rsp_fire) begin
                    // A redirect arriving alongside the response also kills it.
                    if (drop || bus.redirect_valid) begin
                        drop_nxt  = 1'b0;
                        enter_req = 1'b1;
                    end else begin
                        cap_rsp   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end

            HOLD: begin
                if (inst_fire) begin
                    pc_nxt = pc + XLEN'(4);
                end
                // Redirect wins over the sequential PC even when decode takes
                // the current instruction in the same cycle.
                if (bus.redirect_valid) begin
                    pc_nxt = bus.redirect_pc;
                end
                if (inst_fire || bus.redirect_valid) begin
                    enter_req = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A misaligned fetch address never reaches memory: the fault is
        // reported straight to decode instead.
        if (enter_req) begin
            if (misaligned) begin
                state_nxt = HOLD;
                cap_fault = 1'b1;
            end else begin
                state_nxt = REQ;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Handshake outputs, decoded from state
    // -----------------------------------------------------------------------
    always_comb begin
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        inst_valid = 1'b0;
        case (state)
            REQ:     req_valid  = 1'b1;
            WAIT:    rsp_ready  = 1'b1;
            HOLD:    inst_valid = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // PC, drop flag, request address and decode output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            drop        <= 1'b0;
            req_addr    <= RESET_PC;
            inst_q      <= '0;
            inst_pc_q   <= RESET_PC;
            inst_snpc_q <= RESET_PC + XLEN'(4);
            inst_err_q  <= 1'b0;
        end else begin
            pc   <= pc_nxt;
            drop <= drop_nxt;

            // The request address is frozen for the whole REQ visit so that
            // redirects only move pc, never the pending request.
            if (enter_req && !misaligned) begin
                req_addr <= pc_nxt;
            end

            if (cap_rsp) begin
                inst_q      <= bus.imem_rsp_data;
                inst_pc_q   <= pc;
                inst_snpc_q <= pc + XLEN'(4);
                inst_err_q  <= bus.imem_rsp_err;
            end else if (cap_fault) begin
                inst_q      <= '0;
                inst_pc_q   <= pc_nxt;
                inst_snpc_q <= pc_nxt + XLEN'(4);
                inst_err_q  <= 1'b1;
            end
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = req_addr;
    assign bus.imem_rsp_ready = rsp_ready;
    assign bus.inst_valid     = inst_valid;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.inst_snpc      = inst_snpc_q;
    assign bus.inst_err       = inst_err_q;

`ifdef YSYX_25020047_IFU_PERF_EN
    logic stall_en;
    assign stall_en = (state == REQ) || (state == WAIT);

    ysyx_25020047_perfcnt #(.W(32)) u_fetch_cnt (
        .clk (clk),
        .rst (rst),
        .en  (inst_fire),
        .cnt (perf_fetch_cnt)
    );

    ysyx_25020047_perfcnt #(.W(32)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (stall_en),
        .cnt (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25020047_ifu
// Directed scenarios followed by a randomized run. A memory model answers
// fetches from a fixed address->word function; a transaction-level model
// tracks the architectural PC stream (redirect target, else +4 per
// instruction taken by decode) and checks every instruction handed to decode.
// ---------------------------------------------------------------------------
module tb_ysyx_25020047_ifu;
    import ysyx_25020047_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_25020047_ifu_if ifc ();

`ifdef YSYX_25020047_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    ysyx_25020047_ifu #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
`ifdef YSYX_25020047_IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // reference model / environment state
    logic [31:0] exp_pc;
    int          ready_mode;   // 0: always ready, 1: random, 2: never
    int          rsp_delay;
    bit          rsp_rand;
    bit          rnd_inst_ready;
    bit          pend_valid;
    logic [31:0] pend_addr;
    int          pend_wait;
    bit          last_inst_fire;
    logic [31:0] last_pc;
    int          n_fetch;
    int          n_stall;
    bit          prev_hold;
    logic [31:0] prev_inst;
    logic [31:0] prev_pc;
    bit          prev_req_stall;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[9:2] == 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check this cycle's outputs, advance the model, cross
    // the edge, then drive the memory/decode inputs for the next cycle.
    task automatic step();
        bit          req_fire;
        bit          rsp_fire;
        bit          inst_fire;
        logic [31:0] req_addr_s;
        req_fire   = ifc.imem_req_valid && ifc.imem_req_ready;
        rsp_fire   = ifc.imem_rsp_valid && ifc.imem_rsp_ready;
        inst_fire  = ifc.inst_valid && ifc.inst_ready;
        req_addr_s = ifc.imem_req_addr;

        if (prev_hold) begin
            chk("hold_valid", ifc.inst_valid, 1);
            chk("hold_inst", ifc.inst, prev_inst);
            chk("hold_pc", ifc.inst_pc, prev_pc);
        end
        if (prev_req_stall) begin
            chk("req_hold_valid", ifc.imem_req_valid, 1);
            chk("req_hold_addr", ifc.imem_req_addr, prev_addr);
        end
        if (ifc.imem_req_valid) chk("req_aligned", ifc.imem_req_addr[1:0], 0);
        if (ifc.inst_valid) chk("no_req_in_hold", ifc.imem_req_valid, 0);
        if (ifc.imem_rsp_valid) chk("rsp_in_wait", ifc.imem_rsp_ready, 1);

        if (inst_fire) begin
            chk("sb_inst_pc", ifc.inst_pc, exp_pc);
            chk("sb_inst_snpc", ifc.inst_snpc, exp_pc + 32'd4);
            if (exp_pc[1:0] != 2'b00) begin
                chk("sb_inst_fault", ifc.inst, 0);
                chk("sb_err_fault", ifc.inst_err, 1);
            end else begin
                chk("sb_inst", ifc.inst, mem_word(exp_pc));
                chk("sb_err", ifc.inst_err, mem_err(exp_pc));
            end
            n_fetch++;
            last_pc = ifc.inst_pc;
        end
        if (ifc.redirect_valid) exp_pc = ifc.redirect_pc;
        else if (inst_fire) exp_pc = exp_pc + 32'd4;
        if (ifc.imem_req_valid || ifc.imem_rsp_ready) n_stall++;

        prev_hold      = ifc.inst_valid && !ifc.inst_ready && !ifc.redirect_valid;
        prev_inst      = ifc.inst;
        prev_pc        = ifc.inst_pc;
        prev_req_stall = ifc.imem_req_valid && !ifc.imem_req_ready;
        prev_addr      = ifc.imem_req_addr;
        last_inst_fire = inst_fire;

        @(posedge clk);
        #1;
        ifc.redirect_valid = 1'b0;
        if (rsp_fire) pend_valid = 1'b0;
        if (req_fire) begin
            pend_valid = 1'b1;
            pend_addr  = req_addr_s;
            pend_wait  = rsp_rand ? int'($urandom_range(2, 0)) : rsp_delay;
        end else if (pend_valid && pend_wait > 0) begin
            pend_wait--;
        end
        ifc.imem_rsp_valid = pend_valid && (pend_wait == 0);
        ifc.imem_rsp_data  = pend_valid ? mem_word(pend_addr) : 32'h0;
        ifc.imem_rsp_err   = pend_valid ? mem_err(pend_addr) : 1'b0;
        case (ready_mode)
            0:       ifc.imem_req_ready = 1'b1;
            1:       ifc.imem_req_ready = ($urandom_range(3, 0) != 0);
            default: ifc.imem_req_ready = 1'b0;
        endcase
        if (rnd_inst_ready) ifc.inst_ready = $urandom_range(1, 0) != 0;
    endtask

    task automatic wait_inst(input int budget, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!last_inst_fire && n < budget);
        chk(tag, last_inst_fire, 1);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n = 0;
        while (!ifc.inst_valid && n < budget) begin
            step();
            n++;
        end
        chk(tag, ifc.inst_valid, 1);
    endtask

    initial begin
        rst                = 1'b1;
        ifc.imem_req_ready = 1'b1;
        ifc.imem_rsp_valid = 1'b0;
        ifc.imem_rsp_data  = 32'h0;
        ifc.imem_rsp_err   = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = 32'h0;
        ifc.inst_ready     = 1'b0;
        ready_mode = 0; rsp_delay = 0; rsp_rand = 0; rnd_inst_ready = 0;
        pend_valid = 0; pend_addr = 0; pend_wait = 0;
        last_inst_fire = 0; last_pc = 0; n_fetch = 0; n_stall = 0;
        prev_hold = 0; prev_inst = 0; prev_pc = 0; prev_req_stall = 0; prev_addr = 0;
        exp_pc = RST_PC;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", ifc.imem_req_valid, 0);
        chk("rst_req_addr", ifc.imem_req_addr, RST_PC);
        chk("rst_rsp_ready", ifc.imem_rsp_ready, 0);
        chk("rst_inst_valid", ifc.inst_valid, 0);
        chk("rst_inst", ifc.inst, 0);
        chk("rst_inst_pc", ifc.inst_pc, RST_PC);
        chk("rst_inst_snpc", ifc.inst_snpc, RST_PC + 32'd4);
        chk("rst_inst_err", ifc.inst_err, 0);
        rst = 1'b0;

        // first fetch: request, response, instruction three edges after reset
        step();
        chk("t1_req_valid", ifc.imem_req_valid, 1);
        chk("t1_req_addr", ifc.imem_req_addr, 32'h8000_0000);
        chk("t1_no_inst", ifc.inst_valid, 0);
        step();
        chk("t1_wait_no_inst", ifc.inst_valid, 0);
        step();
        chk("t1_inst_valid", ifc.inst_valid, 1);
        chk("t1_inst", ifc.inst, 32'h0010_0093);
        chk("t1_inst_pc", ifc.inst_pc, 32'h8000_0000);
        chk("t1_inst_snpc", ifc.inst_snpc, 32'h8000_0004);

        // decode back-pressure
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_valid", ifc.inst_valid, 1);
            chk("t2_inst", ifc.inst, 32'h0010_0093);
            chk("t2_pc", ifc.inst_pc, 32'h8000_0000);
            chk("t2_no_req", ifc.imem_req_valid, 0);
        end
        ifc.inst_ready = 1'b1;
        step();
        ifc.inst_ready = 1'b0;
        chk("t2_next_valid", ifc.imem_req_valid, 1);
        chk("t2_next_addr", ifc.imem_req_addr, 32'h8000_0004);

        // redirect while waiting for the response
        rsp_delay = 1;
        step();
        chk("t3_rsp_ready", ifc.imem_rsp_ready, 1);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h8000_0100;
        step();
        chk("t3_no_inst", ifc.inst_valid, 0);
        step();
        chk("t3_no_inst2", ifc.inst_valid, 0);
        chk("t3_req_valid", ifc.imem_req_valid, 1);
        chk("t3_req_addr", ifc.imem_req_addr, 32'h8000_0100);
        rsp_delay = 0;
        ifc.inst_ready = 1'b1;
        wait_inst(20, "t3_fetch_timeout");

        // request stalled by memory, redirect while stalled
        ifc.inst_ready     = 1'b0;
        ready_mode         = 2;
        ifc.imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_addr_stable", ifc.imem_req_addr, 32'h8000_0104);
            chk("t4_valid_stable", ifc.imem_req_valid, 1);
            if (i == 1) begin
                ifc.redirect_valid = 1'b1;
                ifc.redirect_pc    = 32'h8000_0200;
            end
            step();
        end
        chk("t4_addr_c5", ifc.imem_req_addr, 32'h8000_0104);
        ready_mode         = 0;
        ifc.imem_req_ready = 1'b1;
        step();
        chk("t4_wait_no_inst", ifc.inst_valid, 0);
        step();
        chk("t4_drop_no_inst", ifc.inst_valid, 0);
        chk("t4_redir_addr", ifc.imem_req_addr, 32'h8000_0200);
        ifc.inst_ready = 1'b1;
        wait_inst(20, "t4_fetch_timeout");

        // misaligned redirect target
        ifc.inst_ready     = 1'b0;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h8000_0102;
        step();
        wait_valid(10, "t5_valid_timeout");
        chk("t5_err", ifc.inst_err, 1);
        chk("t5_inst", ifc.inst, 0);
        chk("t5_pc", ifc.inst_pc, 32'h8000_0102);
        chk("t5_snpc", ifc.inst_snpc, 32'h8000_0106);
        chk("t5_no_req", ifc.imem_req_valid, 0);

        // redirect out of HOLD without handshake, onto a faulting address
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h8000_0168;
        step();
        chk("t6_valid_drop", ifc.inst_valid, 0);
        wait_valid(10, "t6_valid_timeout");
        chk("t6_err", ifc.inst_err, 1);
        chk("t6_pc", ifc.inst_pc, 32'h8000_0168);
        chk("t6_inst", ifc.inst, mem_word(32'h8000_0168));
        ifc.inst_ready = 1'b1;
        step();

        // pc + 4 wraps
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'hFFFF_FFFC;
        wait_inst(30, "t7_fetch_timeout");
        chk("t7_last_pc", last_pc, 32'hFFFF_FFFC);
        wait_inst(30, "t7_wrap_timeout");
        chk("t7_wrap_pc", last_pc, 32'h0000_0000);

        // randomized traffic
        ready_mode     = 1;
        rsp_rand       = 1;
        rnd_inst_ready = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9, 0) == 0) begin
                logic [31:0] tgt;
                tgt = 32'h8000_0000 + ({24'h0, 8'($urandom_range(255, 0))} << 2);
                if ($urandom_range(7, 0) == 0) tgt[1:0] = 2'($urandom_range(3, 1));
                if ($urandom_range(31, 0) == 0) tgt = 32'hFFFF_FFF8;
                ifc.redirect_valid = 1'b1;
                ifc.redirect_pc    = tgt;
            end
            step();
        end
        chk("rnd_progress", 32'(n_fetch > 100), 1);

`ifdef YSYX_25020047_IFU_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, n_fetch);
        chk("perf_stall", perf_stall_cnt, n_stall);
`endif

        // asynchronous reset between clock edges
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_inst_valid", ifc.inst_valid, 0);
        chk("arst_req_valid", ifc.imem_req_valid, 0);
        chk("arst_req_addr", ifc.imem_req_addr, RST_PC);
        chk("arst_inst_pc", ifc.inst_pc, RST_PC);
`ifdef YSYX_25020047_IFU_PERF_EN
        chk("arst_perf_fetch", perf_fetch_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_25020047_ifu.md
Name: ysyx_25020047_ifu

Overview:
Instruction fetch unit that sits directly upstream of the decode stage. It owns the architectural fetch PC and issues word fetches to instruction memory over a valid/ready request/response handshake. It presents each fetched instruction with its PC to decode through a valid/ready output handshake. It accepts PC redirects (dnpc) from execute/writeback and discards any fetches made stale by a redirect.

Parameters:
RESET_PC, 32'h8000_0000, fetch address after reset.
XLEN, 32, address and instruction width; only 32 is supported.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request.
imem_req_addr  out  XLEN  word address of fetch.
imem_rsp_valid  in  1  fetch response valid.
imem_rsp_ready  out  1  IFU accepts response.
imem_rsp_data  in  XLEN  fetched instruction.
imem_rsp_err  in  1  access fault on fetch.
redirect_valid  in  1  one-cycle pulse; next fetch from redirect_pc.
redirect_pc  in  XLEN  redirect target (dnpc).
inst_valid  out  1  instruction available to decode.
inst_ready  in  1  decode consumes instruction.
inst  out  XLEN  instruction word.
inst_pc  out  XLEN  PC of inst.
inst_snpc  out  XLEN  inst_pc + 4.
inst_err  out  1  fetch fault (access error or misaligned PC).

Behaviour:
Clock and reset:
- Single clock, clk.
- rst is asynchronous and active-high.
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, imem_rsp_ready=0, inst_valid=0, inst=0, inst_pc=RESET_PC, inst_snpc=RESET_PC+4, inst_err=0, pc=RESET_PC, drop=0, state=IDLE.

FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE -> REQ on the first clk edge after rst deasserts.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_valid && imem_req_ready -> WAIT.
  - Address and valid stay stable while not accepted. A redirect here does not change the pending request; it updates pc and sets drop=1.
- WAIT:
  - imem_rsp_ready=1.
  - On imem_rsp_valid:
    - If drop=1: discard the response, clear drop, go to REQ with the current pc.
    - Else: register inst=imem_rsp_data, inst_pc=pc, inst_snpc=pc+4, inst_err=imem_rsp_err; go to HOLD.
  - A redirect in WAIT sets drop=1 and pc=redirect_pc.
  - A redirect in the same cycle as the response also forces a drop.
- HOLD:
  - inst_valid=1. Outputs stay stable until handshake or redirect.
  - On inst_valid && inst_ready: pc <= pc+4, go to REQ.
  - On redirect without handshake: inst_valid deasserts next cycle, pc <= redirect_pc, go to REQ.
  - Redirect and handshake in the same cycle: the transfer completes (decode owns the instruction), pc <= redirect_pc, go to REQ.

Redirect priority:
- A redirect always overrides sequential pc+4.
- A redirect in IDLE or REQ-before-accept only updates pc, except in the pending-request case described under REQ.

Misaligned PC:
- Applies when pc[1:0] != 0 on entry to REQ.
- No memory request is issued. Go directly to HOLD with inst=0, inst_err=1, inst_pc=pc.

Timing and arithmetic:
- Latency: request accepted at cycle t, earliest response at t+1, inst_valid at t+2 (registered). Steady-state throughput is one instruction per 3 cycles with zero-wait memory and inst_ready=1.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.

Protocol rule:
- imem_rsp_valid is ignored outside WAIT. The bench flags it as a protocol violation.

Optional Feature:
Macro: YSYX_25020047_IFU_PERF_EN.
- Defined: adds output ports perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on each inst handshake.
  - perf_stall_cnt increments each cycle in REQ or WAIT.
  - Both counters wrap at 2^32.
- Undefined: these ports and their logic do not exist. All other behaviour is identical.

Decomposition:
Package ysyx_25020047_pkg holds:
- the ifu_state_e enum (IDLE, REQ, WAIT, HOLD);
- RESET_PC_DEFAULT;
- INST_NOP=32'h0000_0013;
- XLEN.

One sub-module, ysyx_25020047_perfcnt (a generic enable-increment wrapping counter), is instantiated twice under the macro. No other sub-module.

Test Plan:
- Reset release, memory always ready, rsp one cycle later with data 32'h00100093 -> imem_req_addr=32'h8000_0000; inst_valid at cycle 3 with inst=32'h00100093, inst_pc=32'h8000_0000, inst_snpc=32'h8000_0004.
- inst_ready=0 for 5 cycles in HOLD -> inst and inst_pc stay stable and no new request is issued; on ready, next request addr=32'h8000_0004.
- redirect_valid with redirect_pc=32'h8000_0100 while in WAIT -> stale response dropped, inst_valid stays 0, next request addr=32'h8000_0100.
- imem_req_ready held 0 for 4 cycles, redirect in cycle 2 -> addr stays at the original value until accepted; its response is dropped; the next fetch is at the redirect target.
- redirect_pc=32'h8000_0102 -> no imem request; inst_valid=1, inst_err=1, inst=0, inst_pc=32'h8000_0102.
- imem_rsp_err=1 -> inst_err=1. Under the macro, 10 handshakes give perf_fetch_cnt=10.
